ask_on_fpga: RTL and testbench

Direct-digital-synthesis (DDS) amplitude-shift-keying modulator. A 32-bit phase accumulator drives a 256-entry signed sine lookup table to produce a continuous 16-bit carrier. The carrier is gated on/off by a 1-bit data input to form the on-off-keyed ASK output. The block sits between the baseband bit source and the DAC/analysis path and exposes both the raw carrier and the modulated signal.

---
 rtl/ask_on_fpga_if.sv | 24 ++
 rtl/ask_on_fpga.sv | 70 +++++++
 tb/tb_ask_on_fpga.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ask_on_fpga_if.sv
// Sample-stream bundle for the ASK modulator: keying/tuning inputs and carrier outputs.
interface ask_on_fpga_if;
  logic               data;
  logic        [31:0] increment;
  logic        [7:0]  phase;
  logic signed [15:0] sine;
  logic signed [15:0] ASK;

  modport master (
    output data,
    output increment,
    output phase,
    input  sine,
    input  ASK
  );

  modport slave (
    input  data,
    input  increment,
    input  phase,
    output sine,
    output ASK
  );
endinterface

// File: rtl/ask_on_fpga.sv
// DDS on-off-keyed ASK modulator: 32-bit phase accumulator into a 256-entry full-wave sine ROM.
module ask_on_fpga (
  input  logic                clock,
  input  logic                reset,
  ask_on_fpga_if.slave        bus
);

  // round(32767 * sin(2*pi*k/256)), ties away from zero.
  localparam int SineLut [256] = '{
         0,    804,   1608,   2410,   3212,   4011,   4808,   5602,
      6393,   7179,   7962,   8739,   9512,  10278,  11039,  11793,
     12539,  13279,  14010,  14732,  15446,  16151,  16846,  17530,
     18204,  18868,  19519,  20159,  20787,  21403,  22005,  22594,
     23170,  23731,  24279,  24811,  25329,  25832,  26319,  26790,
     27245,  27683,  28105,  28510,  28898,  29268,  29621,  29956,
     30273,  30571,  30852,  31113,  31356,  31580,  31785,  31971,
     32137,  32285,  32412,  32521,  32609,  32678,  32728,  32757,
     32767,  32757,  32728,  32678,  32609,  32521,  32412,  32285,
     32137,  31971,  31785,  31580,  31356,  31113,  30852,  30571,
     30273,  29956,  29621,  29268,  28898,  28510,  28105,  27683,
     27245,  26790,  26319,  25832,  25329,  24811,  24279,  23731,
     23170,  22594,  22005,  21403,  20787,  20159,  19519,  18868,
     18204,  17530,  16846,  16151,  15446,  14732,  14010,  13279,
     12539,  11793,  11039,  10278,   9512,   8739,   7962,   7179,
      6393,   5602,   4808,   4011,   3212,   2410,   1608,    804,
         0,   -804,  -1608,  -2410,  -3212,  -4011,  -4808,  -5602,
     -6393,  -7179,  -7962,  -8739,  -9512, -10278, -11039, -11793,
    -12539, -13279, -14010, -14732, -15446, -16151, -16846, -17530,
    -18204, -18868, -19519, -20159, -20787, -21403, -22005, -22594,
    -23170, -23731, -24279, -24811, -25329, -25832, -26319, -26790,
    -27245, -27683, -28105, -28510, -28898, -29268, -29621, -29956,
    -30273, -30571, -30852, -31113, -31356, -31580, -31785, -31971,
    -32137, -32285, -32412, -32521, -32609, -32678, -32728, -32757,
    -32767, -32757, -32728, -32678, -32609, -32521, -32412, -32285,
    -32137, -31971, -31785, -31580, -31356, -31113, -30852, -30571,
    -30273, -29956, -29621, -29268, -28898, -28510, -28105, -27683,
    -27245, -26790, -26319, -25832, -25329, -24811, -24279, -23731,
    -23170, -22594, -22005, -21403, -20787, -20159, -19519, -18868,
    -18204, -17530, -16846, -16151, -15446, -14732, -14010, -13279,
    -12539, -11793, -11039, -10278,  -9512,  -8739,  -7962,  -7179,
     -6393,  -5602,  -4808,  -4011,  -3212,  -2410,  -1608,   -804
  };

  logic        [31:0] r_acc;
  logic signed [15:0] r_sine;
  logic signed [15:0] r_ask;
  logic        [7:0]  w_addr;
  logic signed [15:0] w_lut;

  // Address uses the pre-update accumulator; the 8-bit add drops the carry.
  assign w_addr = r_acc[31:24] + bus.phase;
  assign w_lut  = 16'(SineLut[w_addr]);

  // Accumulator free-runs regardless of data so keyed bursts stay phase-coherent.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_acc  <= '0;
      r_sine <= '0;
      r_ask  <= '0;
    end else begin
      r_acc  <= r_acc + bus.increment;
      r_sine <= w_lut;
      r_ask  <= bus.data ? w_lut : 16'sd0;
    end
  end

  assign bus.sine = r_sine;
  assign bus.ASK  = r_ask;

endmodule

// File: tb/tb_ask_on_fpga.sv
// Directed bench for ask_on_fpga: hand-computed carrier/ASK samples at chosen sample indices.
module tb_ask_on_fpga;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;
  int   smp;

  ask_on_fpga_if u_if ();

  ask_on_fpga u_dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic signed [15:0] got, input int exp);
    n_total++;
    if (!$isunknown(got) && int'(got) == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic check_both(input string tag, input int exp_sine, input int exp_ask);
    check_eq({tag, ".sine"}, u_if.sine, exp_sine);
    check_eq({tag, ".ask"}, u_if.ASK, exp_ask);
  endtask

  // Sample k is the k-th negedge after release; sample 0 follows the first posedge.
  task automatic goto_smp(input int k);
    while (smp < k) begin
      @(negedge clk);
      smp++;
    end
  endtask

  task automatic restart(input logic [31:0] inc, input logic [7:0] ph, input logic d);
    @(negedge clk);
    rst_n          = 1'b0;
    u_if.increment = inc;
    u_if.phase     = ph;
    u_if.data      = d;
    @(negedge clk);
    rst_n = 1'b1;
    smp   = -1;
  endtask

  initial begin
    n_total        = 0;
    n_pass         = 0;
    smp            = -1;
    rst_n          = 1'b1;
    u_if.increment = 32'h0800_0000;
    u_if.phase     = 8'd0;
    u_if.data      = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_both("reset", 0, 0);
    repeat (2) @(negedge clk);
    check_both("reset_held", 0, 0);

    // Basic carrier: address step 8, period 32.
    rst_n = 1'b1;
    smp   = -1;
    goto_smp(0);  check_both("basic0", 0, 0);
    goto_smp(1);  check_both("basic1", 6393, 6393);
    goto_smp(4);  check_both("basic4", 23170, 23170);
    goto_smp(8);  check_both("basic8", 32767, 32767);
    goto_smp(16); check_both("basic16", 0, 0);
    goto_smp(20); check_both("basic20", -23170, -23170);
    goto_smp(24); check_both("basic24", -32767, -32767);
    goto_smp(32); check_both("basic32", 0, 0);
    goto_smp(40); check_both("basic40", 32767, 32767);

    // Asynchronous reset between edges, then restart with phase offset 64.
    #2 rst_n = 1'b0;
    #1 check_both("async_rst", 0, 0);
    u_if.phase = 8'd64;
    @(negedge clk);
    rst_n = 1'b1;
    smp   = -1;
    goto_smp(0);  check_both("phase0", 32767, 32767);
    goto_smp(4);  check_both("phase4", 23170, 23170);
    goto_smp(8);  check_both("phase8", 0, 0);
    goto_smp(16); check_both("phase16", -32767, -32767);

    // Keying: data 1 for 200 samples, 0 for 200, then 1 again.
    restart(32'h0800_0000, 8'd0, 1'b1);
    goto_smp(199); check_both("key199", 32137, 32137);
    u_if.data = 1'b0;
    goto_smp(200); check_both("key200", 32767, 0);
    goto_smp(216); check_both("key216", -32767, 0);
    goto_smp(399); check_both("key399", 6393, 0);
    u_if.data = 1'b1;
    goto_smp(401); check_both("key401", -6393, -6393);
    goto_smp(408); check_both("key408", -32767, -32767);

    // Static carrier, then increment latency (2 clocks) and phase latency (1 clock).
    restart(32'd0, 8'd192, 1'b1);
    goto_smp(0); check_both("static0", -32767, -32767);
    goto_smp(5); check_both("static5", -32767, -32767);
    u_if.increment = 32'h4000_0000;
    goto_smp(6); check_eq("inc_lat6", u_if.sine, -32767);
    goto_smp(7); check_eq("inc_lat7", u_if.sine, 0);
    goto_smp(8); check_eq("inc_lat8", u_if.sine, 32767);
    u_if.phase = 8'd193;
    goto_smp(9); check_eq("ph_lat9", u_if.sine, -804);

    // Half-cycle step alternates between phase and phase+128.
    restart(32'h8000_0000, 8'd8, 1'b1);
    goto_smp(0); check_eq("half0", u_if.sine, 6393);
    goto_smp(1); check_eq("half1", u_if.sine, -6393);
    goto_smp(2); check_eq("half2", u_if.sine, 6393);

    // Descending addresses with data off, wrapping 0 -> 255.
    restart(32'hFF00_0000, 8'd0, 1'b0);
    goto_smp(0);   check_both("wrap0", 0, 0);
    goto_smp(1);   check_both("wrap1", -804, 0);
    goto_smp(2);   check_eq("wrap2", u_if.sine, -1608);
    goto_smp(64);  check_eq("wrap64", u_if.sine, -32767);
    goto_smp(192); check_eq("wrap192", u_if.sine, 32767);
    goto_smp(255); check_eq("wrap255", u_if.sine, 804);
    goto_smp(256); check_eq("wrap256", u_if.sine, 0);
    goto_smp(257); check_eq("wrap257", u_if.sine, -804);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
